// File: rtl/linebuf_sched_pkg.sv
// Shared types and helpers for the 3x3 convolution line-buffer scheduler.
// Holds the read FSM state enum, buffer count/pointer width and mask helpers.
package linebuf_sched_pkg;

    localparam int NUM_LB = 4;
    localparam int PTR_W  = 2;

    typedef enum logic {
        IDLE      = 1'b0,
        RD_ACTIVE = 1'b1
    } rd_state_e;

    // Write steering: exactly one buffer selected by the pointer.
    function automatic logic [NUM_LB-1:0] wr_onehot(
        input logic [PTR_W-1:0] ptr
    );
        logic [NUM_LB-1:0] base;
        base      = 4'b0001;
        wr_onehot = base << ptr;
    endfunction

    // Three consecutive buffers starting at ptr (mod 4) form the window;
    // equivalently every buffer except ptr+3 (the one being refilled).
    function automatic logic [NUM_LB-1:0] rd_mask(
        input logic [PTR_W-1:0] ptr
    );
        logic [PTR_W-1:0]  skip;
        logic [NUM_LB-1:0] base;
        skip    = ptr + 2'd3;
        base    = 4'b0001;
        rd_mask = ~(base << skip);
    endfunction

endpackage

// File: rtl/linebuf_line_ptr.sv
// Column counter with wrap at IMG_WIDTH-1 plus a 2-bit line-buffer pointer.
// Ports: clk, rst_n (async low), en (advance), ptr (buffer index), wrap (last column taken).
module linebuf_line_ptr
    import linebuf_sched_pkg::*;
#(
    parameter int IMG_WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [PTR_W-1:0] ptr,
    output logic             wrap
);

    localparam int COL_W = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

    logic [COL_W-1:0] col;

    assign wrap = en && (col == COL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            ptr <= '0;
        end else if (en) begin
            if (wrap) begin
                col <= '0;
                ptr <= ptr + 2'd1;
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/linebuf_scheduler.sv
// Sequencer for the 3x3 convolution front end: round-robin line writes, 3-line window reads.
// Ports: axi_clk, axi_reset (async low), i_pixel_data_valid, i_out_ready,
//        o_lb_wr_en, o_lb_rd_en, o_rd_sel, o_pixel_data_valid, o_intr, o_overflow.
// Build option: LINEBUF_SCHED_OVERFLOW_CHK_EN drops writes into a full set of buffers
//        and raises a sticky o_overflow; without it o_overflow is tied 0.
module linebuf_scheduler #(
    parameter int IMG_WIDTH = 512,
    parameter int NUM_LB    = 4
) (
    input  logic              axi_clk,
    input  logic              axi_reset,
    input  logic              i_pixel_data_valid,
    input  logic              i_out_ready,
    output logic [NUM_LB-1:0] o_lb_wr_en,
    output logic [NUM_LB-1:0] o_lb_rd_en,
    output logic [1:0]        o_rd_sel,
    output logic              o_pixel_data_valid,
    output logic              o_intr,
    output logic              o_overflow
);

    import linebuf_sched_pkg::*;

    localparam int FILL_W = $clog2(4 * IMG_WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(4 * IMG_WIDTH);
    localparam logic [FILL_W-1:0] FILL_START = FILL_W'(3 * IMG_WIDTH);

    rd_state_e         state;
    rd_state_e         state_nxt;
    logic [FILL_W-1:0] fill_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_wrap;
    logic              rd_wrap;
    logic              wr_acc;
    logic              rd_fire;
    logic              ovf_drop;
    logic              ovf_q;
    logic              valid_q;
    logic              intr_q;

    assign rd_fire = (state == RD_ACTIVE) && i_out_ready;

`ifdef LINEBUF_SCHED_OVERFLOW_CHK_EN
    // A read in the same cycle frees a slot, so only an unpaired write overflows.
    assign ovf_drop = i_pixel_data_valid && !rd_fire
                   && (fill_cnt == FILL_FULL);

    always_ff @(posedge axi_clk or negedge axi_reset) begin
        if (!axi_reset) begin
            ovf_q <= 1'b0;
        end else if (ovf_drop) begin
            ovf_q <= 1'b1;
        end
    end
`else
    assign ovf_drop = 1'b0;
    assign ovf_q    = 1'b0;
`endif

    assign wr_acc = i_pixel_data_valid && !ovf_drop;

    linebuf_line_ptr #(
        .IMG_WIDTH (IMG_WIDTH)
    ) u_wr_ptr (
        .clk   (axi_clk),
        .rst_n (axi_reset),
        .en    (wr_acc),
        .ptr   (wr_ptr),
        .wrap  (wr_wrap)
    );

    linebuf_line_ptr #(
        .IMG_WIDTH (IMG_WIDTH)
    ) u_rd_ptr (
        .clk   (axi_clk),
        .rst_n (axi_reset),
        .en    (rd_fire),
        .ptr   (rd_ptr),
        .wrap  (rd_wrap)
    );

    always_ff @(posedge axi_clk or negedge axi_reset) begin
        if (!axi_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Leaving RD_ACTIVE always lands in IDLE for one cycle, even when
    // the next window is already buffered.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fill_cnt >= FILL_START) begin
                    state_nxt = RD_ACTIVE;
                end
            end
            RD_ACTIVE: begin
                if (rd_wrap) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset) begin
        if (!axi_reset) begin
            fill_cnt <= '0;
        end else if (wr_acc && !rd_fire) begin
            fill_cnt <= fill_cnt + FILL_W'(1);
        end else if (rd_fire && !wr_acc) begin
            fill_cnt <= fill_cnt - FILL_W'(1);
        end
    end

    // Line buffers register their output, so valid trails the read by one.
    always_ff @(posedge axi_clk or negedge axi_reset) begin
        if (!axi_reset) begin
            valid_q <= 1'b0;
            intr_q  <= 1'b0;
        end else begin
            valid_q <= rd_fire;
            intr_q  <= rd_wrap;
        end
    end

    assign o_lb_wr_en         = wr_onehot(wr_ptr) & {NUM_LB{wr_acc}};
    assign o_lb_rd_en         = rd_fire ? rd_mask(rd_ptr) : '0;
    assign o_rd_sel           = rd_ptr;
    assign o_pixel_data_valid = valid_q;
    assign o_intr             = intr_q;
    assign o_overflow         = ovf_q;

    // Write wrap is implied by the pointer advancing; kept visible for debug.
    logic unused_wr_wrap;
    assign unused_wr_wrap = wr_wrap;

endmodule

// File: tb/tb_linebuf_scheduler.sv
// Directed bench for linebuf_scheduler at IMG_WIDTH=4.
// Covers fill, rotation, stall, simultaneous r/w, async reset and overflow.
`timescale 1ns/1ps
module tb_linebuf_scheduler;

    localparam int W = 4;

    logic       axi_clk   = 1'b0;
    logic       axi_reset = 1'b0;
    logic       vin       = 1'b0;
    logic       rdy       = 1'b0;
    logic [3:0] wr_en;
    logic [3:0] rd_en;
    logic [1:0] rd_sel;
    logic       vout;
    logic       intr;
    logic       ovf;

    int n_chk = 0;
    int n_err = 0;

    always #5 axi_clk = ~axi_clk;

    linebuf_scheduler #(
        .IMG_WIDTH (W),
        .NUM_LB    (4)
    ) dut (
        .axi_clk            (axi_clk),
        .axi_reset          (axi_reset),
        .i_pixel_data_valid (vin),
        .i_out_ready        (rdy),
        .o_lb_wr_en         (wr_en),
        .o_lb_rd_en         (rd_en),
        .o_rd_sel           (rd_sel),
        .o_pixel_data_valid (vout),
        .o_intr             (intr),
        .o_overflow         (ovf)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic r);
        @(negedge axi_clk);
        vin = v;
        rdy = r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge axi_clk);
        vin       = 1'b0;
        rdy       = 1'b0;
        axi_reset = 1'b0;
        @(negedge axi_clk);
        @(negedge axi_clk);
        axi_reset = 1'b1;
        #1;
    endtask

    // Fill: per-cycle expectations after the 12th pixel
    logic [3:0] f_rd [8]  = '{0, 7, 7, 7, 7, 0, 0, 0};
    logic       f_v  [8]  = '{0, 0, 1, 1, 1, 1, 0, 0};
    logic       f_i  [8]  = '{0, 0, 0, 0, 0, 1, 0, 0};
    logic [1:0] f_s  [8]  = '{0, 0, 0, 0, 0, 1, 1, 1};

    // Stall: ready dropped for 3 cycles at rd_col=2
    logic       s_r  [11] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    logic [3:0] s_rd [11] = '{0, 7, 7, 0, 0, 0, 7, 7, 0, 0, 0};
    logic       s_v  [11] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0};
    logic       s_i  [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    // Rotation: window masks for successive read lines
    logic [3:0] r_mask [5] = '{4'h7, 4'hE, 4'hD, 4'hB, 4'h7};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lines;
        int intrs;
        int vcnt;
        logic [3:0] prev;

        // Reset state
        do_reset();
        check("rst_wr", wr_en, 0);
        check("rst_rd", rd_en, 0);
        check("rst_sel", rd_sel, 0);
        check("rst_v", vout, 0);
        check("rst_intr", intr, 0);
        check("rst_ovf", ovf, 0);

        // Fill: 12 pixels walk buffers 0,1,2
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b1);
            check("fill_wr", wr_en, 32'd1 << (i / 4));
            check("fill_rd", rd_en, 0);
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1);
            check("fill_rdmask", rd_en, f_rd[k]);
            check("fill_valid", vout, f_v[k]);
            check("fill_intr", intr, f_i[k]);
            check("fill_sel", rd_sel, f_s[k]);
        end
        check("fill_cnt", dut.fill_cnt, 8);

        // Rotation: 28 pixels streamed, five lines can be read out
        do_reset();
        lines = 0;
        intrs = 0;
        prev  = '0;
        for (int n = 1; n <= 40; n++) begin
            drive(n <= 28, 1'b1);
            if (n >= 19 && n <= 22)
                check("simul_fill", dut.fill_cnt, 14);
            if (rd_en != 0 && prev == 0) begin
                if (lines < 5) begin
                    check("rot_mask", rd_en, r_mask[lines]);
                    check("rot_sel", rd_sel, lines % 4);
                end
                lines++;
            end
            prev = rd_en;
            if (intr) intrs++;
        end
        check("rot_lines", lines, 5);
        check("rot_intr", intrs, 5);
        drive(1'b1, 1'b0);
        check("rot_wrptr", wr_en, 4'b1000);
        drive(1'b0, 1'b0);

        // Stall mid-line
        do_reset();
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b1);
        vcnt  = 0;
        intrs = 0;
        for (int k = 0; k < 11; k++) begin
            drive(1'b0, s_r[k]);
            check("stall_rd", rd_en, s_rd[k]);
            check("stall_v", vout, s_v[k]);
            check("stall_intr", intr, s_i[k]);
            if (vout) vcnt++;
            if (intr) intrs++;
        end
        check("stall_vcnt", vcnt, 4);
        check("stall_icnt", intrs, 1);
        check("stall_sel", rd_sel, 1);

        // Async reset mid-read at rd_col=1
        do_reset();
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1);
        check("pre_rst_v", vout, 1);
        axi_reset = 1'b0;
        #1;
        check("arst_wr", wr_en, 0);
        check("arst_rd", rd_en, 0);
        check("arst_sel", rd_sel, 0);
        check("arst_v", vout, 0);
        check("arst_intr", intr, 0);
        check("arst_ovf", ovf, 0);
        @(negedge axi_clk);
        axi_reset = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 1'b1);
            check("rerd_early", rd_en, 0);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1);
            check("rerd_wait", rd_en, 0);
            check("rerd_intr", intr, 0);
        end
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        check("rerd_idle", rd_en, 0);
        drive(1'b0, 1'b1);
        check("rerd_go", rd_en, 4'h7);

        // Overflow: 16 pixels with reads blocked, then a 17th
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0);
            check("ovf_rd", rd_en, 0);
        end
        drive(1'b1, 1'b0);
`ifdef LINEBUF_SCHED_OVERFLOW_CHK_EN
        check("ovf_wr17", wr_en, 0);
        drive(1'b0, 1'b0);
        check("ovf_flag", ovf, 1);
        check("ovf_fill", dut.fill_cnt, 16);
        drive(1'b0, 1'b1);
        check("ovf_sticky", ovf, 1);
`else
        check("ovf_wr17", wr_en, 4'b0001);
        drive(1'b0, 1'b0);
        check("ovf_flag", ovf, 0);
        check("ovf_fill", dut.fill_cnt, 17);
        drive(1'b0, 1'b1);
        check("ovf_sticky", ovf, 0);
`endif
        do_reset();
        check("ovf_clr", ovf, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
